// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-network MNIST datapath.
// The global state encoding is shared by the sequencer and every layer block.
package bnn_pkg;

    localparam int IMG_DIM = 28;
    localparam int CLASS_W = 4;

    typedef enum logic [2:0] {
        s_IDLE    = 3'b000,
        s_LOAD    = 3'b001,
        s_LAYER_1 = 3'b010,
        s_LAYER_2 = 3'b011,
        s_LAYER_3 = 3'b100,
        s_DONE    = 3'b101
    } state_t;

    function automatic logic is_layer_state(input state_t s);
        return (s == s_LAYER_1) || (s == s_LAYER_2) || (s == s_LAYER_3);
    endfunction

endpackage

// File: rtl/bnn_pix_addr_gen.sv
// Row-major pixel address generator for image-buffer writes.
// The column runs fastest; the transfer at the last pixel wraps both counters to zero.
module bnn_pix_addr_gen #(
    parameter int IMG_DIM = bnn_pkg::IMG_DIM
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       advance,
    output logic [4:0] row,
    output logic [4:0] col,
    output logic       last
);

    localparam logic [4:0] DIM_MAX = 5'(IMG_DIM - 1);

    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;

    assign last = (row_q == DIM_MAX) && (col_q == DIM_MAX);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_q == DIM_MAX) begin
                col_d = '0;
                row_d = last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/bnn_sequencer.sv
// Top-level sequencer: pixel load, layer walk, class capture and latency count.
// Define BNN_SEQ_WATCHDOG_EN to abort a stuck layer after TIMEOUT cycles and flag error.
module bnn_sequencer #(
    parameter int IMG_DIM = bnn_pkg::IMG_DIM,
    parameter int CLASS_W = bnn_pkg::CLASS_W,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pix_valid,
    input  logic               pix_bit,
    output logic               pix_ready,
    output logic               pix_we,
    output logic [4:0]         pix_row,
    output logic [4:0]         pix_col,
    output logic [2:0]         state,
    output logic               layer_rst_n,
    input  logic               l1_done,
    input  logic               l2_done,
    input  logic               l3_done,
    input  logic [CLASS_W-1:0] l3_class,
    output logic [CLASS_W-1:0] result,
    output logic               result_valid,
    output logic [CNT_W-1:0]   latency,
    output logic               error
);

    import bnn_pkg::*;

    state_t state_q, state_d;

    logic               start_acc;
    logic               xfer;
    logic               last_pix;
    logic               in_layer;
    logic               cur_done;
    logic               wd_fire;

    logic [CLASS_W-1:0] result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic [CNT_W-1:0]   latency_q, latency_d;
    logic               layer_rst_n_q, layer_rst_n_d;

    // The image buffer takes pix_bit directly; only the strobe and address come from here.
    logic unused_pix_bit;
    assign unused_pix_bit = pix_bit;

    assign start_acc = start && (state_q == s_IDLE || state_q == s_DONE);
    assign xfer      = pix_valid && (state_q == s_LOAD);
    assign in_layer  = is_layer_state(state_q);

    always_comb begin
        case (state_q)
            s_LAYER_1: cur_done = l1_done;
            s_LAYER_2: cur_done = l2_done;
            s_LAYER_3: cur_done = l3_done;
            default:   cur_done = 1'b0;
        endcase
    end

    bnn_pix_addr_gen #(
        .IMG_DIM(IMG_DIM)
    ) u_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (start_acc),
        .advance(xfer),
        .row    (pix_row),
        .col    (pix_col),
        .last   (last_pix)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= s_IDLE;
        else        state_q <= state_d;
    end

    // A layer's done wins over a watchdog expiry landing on the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            s_IDLE, s_DONE: if (start_acc) state_d = s_LOAD;
            s_LOAD:         if (xfer && last_pix) state_d = s_LAYER_1;
            s_LAYER_1:      if (l1_done) state_d = s_LAYER_2;
                            else if (wd_fire) state_d = s_IDLE;
            s_LAYER_2:      if (l2_done) state_d = s_LAYER_3;
                            else if (wd_fire) state_d = s_IDLE;
            s_LAYER_3:      if (l3_done) state_d = s_DONE;
                            else if (wd_fire) state_d = s_IDLE;
            default:        state_d = s_IDLE;
        endcase
    end

    always_comb begin
        pix_ready      = (state_q == s_LOAD);
        pix_we         = pix_valid && pix_ready;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        latency_d      = latency_q;
        layer_rst_n_d  = !start_acc;
        if (start_acc) begin
            latency_d      = '0;
            result_valid_d = 1'b0;
        end else if ((state_q == s_LOAD || in_layer) && latency_q != '1) begin
            latency_d = latency_q + 1'b1;
        end
        if (state_q == s_LAYER_3 && l3_done) begin
            result_d       = l3_class;
            result_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            latency_q      <= '0;
            layer_rst_n_q  <= 1'b0;
        end else begin
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            latency_q      <= latency_d;
            layer_rst_n_q  <= layer_rst_n_d;
        end
    end

`ifdef BNN_SEQ_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [WD_W-1:0] wd_q, wd_d;
    logic            error_q, error_d;

    assign wd_fire = in_layer && !cur_done && (wd_q == WD_W'(TIMEOUT - 1));

    // Any state change restarts the count, so each layer gets a fresh budget.
    always_comb begin
        wd_d    = wd_q;
        error_d = error_q;
        if (state_d != state_q) wd_d = '0;
        else if (in_layer)      wd_d = wd_q + 1'b1;
        if (start_acc)    error_d = 1'b0;
        else if (wd_fire) error_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
    assign wd_fire        = 1'b0;
    assign error          = 1'b0;
`endif

    assign state        = state_q;
    assign layer_rst_n  = layer_rst_n_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign latency      = latency_q;

endmodule
